// File: rtl/pipe_skid_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : pipe_skid_stage_if
// Brief    : Handshake bundle for one pipe_skid_stage boundary. It carries the
//            upstream valid/ready/data, the downstream valid/ready/data, the
//            stage flush and the occupancy report.
//            master = environment side (upstream producer + downstream consumer)
//            slave  = the stage itself
// Revision : 1.0 - initial release
// ============================================================================
interface pipe_skid_stage_if #(
  parameter int DATA_W = 64
) ();

  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;
  logic              flush;
  logic [1:0]        occupancy;

  modport master (
    output in_valid, in_data, out_ready, flush,
    input  in_ready, out_valid, out_data, occupancy
  );

  modport slave (
    input  in_valid, in_data, out_ready, flush,
    output in_ready, out_valid, out_data, occupancy
  );

endinterface
`default_nettype wire

// File: rtl/pipe_skid_stage.sv
`default_nettype none
// ============================================================================
// Module   : pipe_skid_stage
// Brief    : Two-entry skid-buffer pipeline register with valid/ready flow
//            control, synchronous flush and registered backpressure.
//            Slot "main" drives the output and slot "skid" absorbs the one
//            payload accepted in the cycle a downstream stall first appears.
//            Optional build macro PIPE_SKID_ZERO_EN: clears every slot that
//            becomes invalid, so out_data reads 0 whenever out_valid is 0.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_skid_stage #(
  parameter int DATA_W = 64
) (
  input wire               clk,
  input wire               reset,     // asynchronous, active-low
  pipe_skid_stage_if.slave bus
);

`ifdef PIPE_SKID_ZERO_EN
  localparam bit c_zero_en = 1'b1;
`else
  localparam bit c_zero_en = 1'b0;
`endif

  // Encoding equals the number of held entries, so occupancy is the state.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [DATA_W-1:0] r_main;
  logic [DATA_W-1:0] r_skid;
  logic [DATA_W-1:0] w_main_nxt;
  logic [DATA_W-1:0] w_skid_nxt;
  logic              w_in_ready;
  logic              w_out_valid;
  logic              w_in_fire;
  logic              w_out_fire;

  // Outputs decode registered state only: no out_ready->in_ready path and no
  // in_*->out_* path exists through this stage.
  assign w_in_ready    = (r_state != ST_FULL);
  assign w_out_valid   = (r_state != ST_EMPTY);
  assign w_in_fire     = bus.in_valid & w_in_ready;
  assign w_out_fire    = w_out_valid & bus.out_ready;

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_data  = r_main;
  assign bus.occupancy = 2'(r_state);

  // Next-state and slot-update logic; flush overrides every normal transition.
  always_comb begin
    w_state_nxt = r_state;
    w_main_nxt  = r_main;
    w_skid_nxt  = r_skid;

    if (bus.flush) begin
      // An out_fire this cycle has already been delivered; an in_fire is lost.
      w_state_nxt = ST_EMPTY;
      if (c_zero_en) begin
        w_main_nxt = '0;
        w_skid_nxt = '0;
      end
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_in_fire) begin
            w_state_nxt = ST_ONE;
            w_main_nxt  = bus.in_data;
          end
        end

        ST_ONE: begin
          if (w_in_fire && w_out_fire) begin
            w_main_nxt = bus.in_data;
          end else if (w_in_fire) begin
            // Downstream stalled while we accepted: park the younger payload.
            w_state_nxt = ST_FULL;
            w_skid_nxt  = bus.in_data;
          end else if (w_out_fire) begin
            w_state_nxt = ST_EMPTY;
            if (c_zero_en) begin
              w_main_nxt = '0;
            end
          end
        end

        ST_FULL: begin
          // in_ready is low here, so only the drain side can move.
          if (w_out_fire) begin
            w_state_nxt = ST_ONE;
            w_main_nxt  = r_skid;
            if (c_zero_en) begin
              w_skid_nxt = '0;
            end
          end
        end

        default: begin
          // Unreachable encoding: recover to a clean empty stage.
          w_state_nxt = ST_EMPTY;
          if (c_zero_en) begin
            w_main_nxt = '0;
            w_skid_nxt = '0;
          end
        end
      endcase
    end
  end

  // State and payload registers with asynchronous clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_EMPTY;
      r_main  <= '0;
      r_skid  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_main  <= w_main_nxt;
      r_skid  <= w_skid_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipe_skid_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_skid_stage
// Brief    : Self-checking bench for pipe_skid_stage. A FIFO-queue model of the
//            64-bit stage is compared every cycle; directed scenarios pin the
//            model with literal values; 1-bit and 130-bit stages run random
//            valid/ready traffic against in-order scoreboards.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_skid_stage;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad   = 0;
  bit   chk_en = 1'b0;
  bit   rnd_en = 1'b0;

  always #5 clk = ~clk;

  pipe_skid_stage_if #(.DATA_W(64))  if64 ();
  pipe_skid_stage_if #(.DATA_W(1))   if1 ();
  pipe_skid_stage_if #(.DATA_W(130)) if130 ();

  pipe_skid_stage #(.DATA_W(64))  u_dut64  (.clk(clk), .reset(reset), .bus(if64));
  pipe_skid_stage #(.DATA_W(1))   u_dut1   (.clk(clk), .reset(reset), .bus(if1));
  pipe_skid_stage #(.DATA_W(130)) u_dut130 (.clk(clk), .reset(reset), .bus(if130));

  task automatic check(input string name, input logic [129:0] act, input logic [129:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Behavioural model of the 64-bit stage: a FIFO of at most two payloads.
  logic [63:0] mq[$];
  logic [63:0] last_out = '0;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mq.delete();
    end else begin : m_upd
      bit ofire;
      bit ifire;
      ofire = (mq.size() > 0) && if64.out_ready;
      ifire = if64.in_valid && (mq.size() < 2);
      if (ofire) last_out = mq[0];
      if (if64.flush) begin
        mq.delete();
      end else begin
        if (ofire) void'(mq.pop_front());
        if (ifire) mq.push_back(if64.in_data);
      end
    end
  end

  // Per-cycle comparison of the 64-bit stage against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("occupancy", 130'(if64.occupancy), 130'(mq.size()));
      check("in_ready",  130'(if64.in_ready),  130'(mq.size() < 2));
      check("out_valid", 130'(if64.out_valid), 130'(mq.size() > 0));
      if (mq.size() > 0) check("out_data", 130'(if64.out_data), 130'(mq[0]));
`ifdef PIPE_SKID_ZERO_EN
      else check("bubble_zero", 130'(if64.out_data), 130'(0));
`endif
    end
  end

  // Scoreboard for the 1-bit stage under random traffic.
  logic [129:0] sq1[$];
  logic         p1_stall = 1'b0;
  logic [0:0]   p1_data  = '0;
  always @(negedge clk) begin
    if (rnd_en && reset) begin
      check("w1_occ",   130'(if1.occupancy), 130'(sq1.size()));
      check("w1_valid", 130'(if1.out_valid), 130'(sq1.size() > 0));
      check("w1_ready", 130'(if1.in_ready),  130'(sq1.size() < 2));
      if (if1.out_valid && sq1.size() > 0) check("w1_data", 130'(if1.out_data), sq1[0]);
      if (p1_stall) check("w1_hold", 130'(if1.out_data), 130'(p1_data));
      p1_stall = if1.out_valid & ~if1.out_ready;
      p1_data  = if1.out_data;
      if (if1.out_valid && if1.out_ready && sq1.size() > 0) void'(sq1.pop_front());
      if (if1.in_valid && if1.in_ready) sq1.push_back(130'(if1.in_data));
    end
  end

  // Scoreboard for the 130-bit stage under random traffic.
  logic [129:0] sq130[$];
  logic         p130_stall = 1'b0;
  logic [129:0] p130_data  = '0;
  always @(negedge clk) begin
    if (rnd_en && reset) begin
      check("w130_occ",   130'(if130.occupancy), 130'(sq130.size()));
      check("w130_valid", 130'(if130.out_valid), 130'(sq130.size() > 0));
      check("w130_ready", 130'(if130.in_ready),  130'(sq130.size() < 2));
      if (if130.out_valid && sq130.size() > 0) check("w130_data", if130.out_data, sq130[0]);
      if (p130_stall) check("w130_hold", if130.out_data, p130_data);
      p130_stall = if130.out_valid & ~if130.out_ready;
      p130_data  = if130.out_data;
      if (if130.out_valid && if130.out_ready && sq130.size() > 0) void'(sq130.pop_front());
      if (if130.in_valid && if130.in_ready) sq130.push_back(if130.in_data);
    end
  end

  initial begin
    logic [159:0] wide;
    if64.in_valid = 0;  if64.in_data = '0;  if64.out_ready = 0;  if64.flush = 0;
    if1.in_valid = 0;   if1.in_data = '0;   if1.out_ready = 0;   if1.flush = 0;
    if130.in_valid = 0; if130.in_data = '0; if130.out_ready = 0; if130.flush = 0;

    // Asynchronous reset before any clock edge.
    #2 reset = 1'b0;
    #1;
    check("rst_out_valid", 130'(if64.out_valid), 130'(0));
    check("rst_occupancy", 130'(if64.occupancy), 130'(0));
    check("rst_in_ready",  130'(if64.in_ready),  130'(1));
    check("rst_out_data",  130'(if64.out_data),  130'(0));
    #9 reset = 1'b1;
    chk_en = 1'b1;
    tick();

    // Streaming 1..8 with downstream always ready.
    if64.out_ready = 1;
    for (int i = 1; i <= 8; i++) begin
      if64.in_valid = 1;
      if64.in_data  = 64'(i);
      tick();
      check("stream_data", 130'(if64.out_data), 130'(i));
      check("stream_occ",  130'(if64.occupancy), 130'(1));
      check("stream_rdy",  130'(if64.in_ready), 130'(1));
    end
    if64.in_valid = 0;
    tick();
    check("stream_drained", 130'(if64.out_valid), 130'(0));

    // Stall absorb: 0xA drains, then stall while 0xB and 0xC arrive.
    if64.in_valid = 1; if64.in_data = 64'hA; if64.out_ready = 1; tick();
    if64.in_data = 64'hB; tick();
    check("stall_a_seen", 130'(last_out), 130'(64'hA));
    if64.in_data = 64'hC; if64.out_ready = 0; tick();
    check("stall_occ2",  130'(if64.occupancy), 130'(2));
    check("stall_nrdy",  130'(if64.in_ready),  130'(0));
    check("stall_main",  130'(if64.out_data),  130'(64'hB));
    if64.in_valid = 0; tick();
    check("stall_hold",  130'(if64.out_data),  130'(64'hB));
    if64.out_ready = 1; tick();
    check("stall_next",  130'(if64.out_data),  130'(64'hC));
    check("stall_occ1",  130'(if64.occupancy), 130'(1));
    tick();
    check("stall_last_out", 130'(last_out), 130'(64'hC));
    check("stall_empty", 130'(if64.out_valid), 130'(0));

    // Flush while FULL, with a payload offered in the flush cycle.
    if64.out_ready = 0; if64.in_valid = 1; if64.in_data = 64'h21; tick();
    if64.in_data = 64'h22; tick();
    check("ff_occ2", 130'(if64.occupancy), 130'(2));
    if64.flush = 1; if64.in_data = 64'h55; tick();
    if64.flush = 0; if64.in_valid = 0;
    check("ff_valid", 130'(if64.out_valid), 130'(0));
    check("ff_occ0",  130'(if64.occupancy), 130'(0));
    check("ff_rdy",   130'(if64.in_ready),  130'(1));
    tick();
    check("ff_no55",  130'(if64.out_valid), 130'(0));

    // Flush coinciding with the delivery of 0x11.
    if64.in_valid = 1; if64.in_data = 64'h11; tick();
    if64.in_valid = 0; if64.out_ready = 1; if64.flush = 1; tick();
    if64.flush = 0;
    check("fo_consumed", 130'(last_out), 130'(64'h11));
    check("fo_occ0",     130'(if64.occupancy), 130'(0));
    check("fo_valid",    130'(if64.out_valid), 130'(0));
`ifdef PIPE_SKID_ZERO_EN
    check("fo_zero",     130'(if64.out_data), 130'(0));
`endif

    // Asynchronous reset in the middle of a FULL cycle.
    if64.out_ready = 0; if64.in_valid = 1; if64.in_data = 64'h31; tick();
    if64.in_data = 64'h32; tick();
    if64.in_valid = 0;
    check("ar_full", 130'(if64.occupancy), 130'(2));
    #2 reset = 1'b0;
    #1;
    check("ar_valid", 130'(if64.out_valid), 130'(0));
    check("ar_occ",   130'(if64.occupancy), 130'(0));
    check("ar_rdy",   130'(if64.in_ready),  130'(1));
    check("ar_data",  130'(if64.out_data),  130'(0));
    tick();
    #3 reset = 1'b1;
    tick();
    if64.in_valid = 1; if64.in_data = 64'h77; if64.out_ready = 1; tick();
    if64.in_valid = 0;
    check("ar_first_data",  130'(if64.out_data),  130'(64'h77));
    check("ar_first_valid", 130'(if64.out_valid), 130'(1));
    tick();

    // Width sweep with random valid/ready traffic.
    rnd_en = 1'b1;
    for (int n = 0; n < 400; n++) begin
      if1.in_valid   = 1'($urandom_range(0, 1));
      if1.in_data    = 1'($urandom_range(0, 1));
      if1.out_ready  = 1'($urandom_range(0, 2) != 0);
      wide = {$urandom, $urandom, $urandom, $urandom, $urandom};
      if130.in_valid  = 1'($urandom_range(0, 1));
      if130.in_data   = wide[129:0];
      if130.out_ready = 1'($urandom_range(0, 2) != 0);
      tick();
    end
    if1.in_valid = 0;   if1.out_ready = 1;
    if130.in_valid = 0; if130.out_ready = 1;
    repeat (4) tick();
    check("w1_drained",   130'(if1.occupancy),   130'(sq1.size()));
    check("w130_drained", 130'(if130.occupancy), 130'(sq130.size()));
    check("w130_empty",   130'(if130.out_valid), 130'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipe_skid_stage.md
# pipe_skid_stage

Parametrised, handshaked pipeline stage register for the dual-issue pipeline stage boundaries (ID/EX, EX/MEM, MEM/WB). It replaces the flush-only stage latch with a 2-entry skid buffer: valid/ready flow control, per-stage flush and registered backpressure. Any lane's control and data bundle can be packed into one payload vector. Full throughput is kept without a combinational ready path between stages.

## Interface
- DATA_W, default 64: payload width in bits (packed control + data bundle), minimum 1.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- in_valid  input  1  upstream presents a payload.
- in_data  input  DATA_W  upstream payload.
- in_ready  output  1  stage can accept; registered.
- out_valid  output  1  stage presents a payload; registered.
- out_data  output  DATA_W  downstream payload; registered.
- out_ready  input  1  downstream accepts.
- flush  input  1  synchronous kill of all held entries.
- occupancy  output  2  number of valid entries held, 0..2.

## Operation
- Two storage slots: main (drives out_data/out_valid) and skid (overflow).
- in_fire = in_valid & in_ready. out_fire = out_valid & out_ready.
- States are EMPTY (0 entries), ONE (main valid) and FULL (main and skid valid). occupancy is 0, 1 or 2 respectively.
- EMPTY:
  - in_fire -> ONE, main <= in_data.
  - Otherwise stay in EMPTY.
- ONE:
  - in_fire & out_fire -> ONE, main <= in_data.
  - in_fire & !out_fire -> FULL, skid <= in_data.
  - !in_fire & out_fire -> EMPTY.
  - Otherwise hold.
- FULL:
  - in_ready = 0, so no input is accepted.
  - out_fire -> ONE, main <= skid.
  - Otherwise hold.
- in_ready = (state != FULL). It is a function of registered state only.
- Ordering is strict FIFO: skid contents are always younger than main contents.
- Priority is reset > flush > normal update.
- flush = 1 at a clock edge:
  - Next state is EMPTY.
  - Any in_fire in that cycle is discarded.
  - Any out_fire in that cycle still counts as delivered downstream. Flush does not recall it.
- Payload never changes while out_valid = 1 and out_ready = 0 (hold under stall).
- Reset values: out_valid = 0, occupancy = 0, in_ready = 1, out_data = 0, internal skid = 0.

## Timing
- Latency is 1 cycle: a payload accepted at edge N appears on out_data after edge N with out_valid = 1, when the stage was EMPTY or draining.
- Throughput is 1 payload per cycle in steady flow with out_ready held 1.
- in_ready responds to downstream stall one cycle late. The skid slot absorbs the one payload accepted during that cycle.
- No combinational path from out_ready to in_ready, or from in_* to out_*.
- Flush takes effect at the next edge:
  - out_valid = 0 and in_ready = 1 in the following cycle.
  - A flush while FULL drops both entries.
- Reset asserted mid-operation clears all state immediately, without waiting for a clock edge. Normal operation resumes on the first edge after deassertion.

## Configuration
- Macro PIPE_SKID_ZERO_EN.
- Defined:
  - Every slot that becomes invalid (flush, drain to EMPTY, skid moved into main) has its payload cleared to 0.
  - out_data = 0 whenever out_valid = 0.
  - This keeps bubble payloads identical to the zeroed flush bundles the downstream hazard and forwarding logic expects.
- Undefined:
  - Invalid slots keep stale payload, which saves enables and toggling.
  - out_data is meaningful only while out_valid = 1.
- Valid, ready and occupancy behaviour is identical in both builds.

## Test plan
- Streaming: out_ready = 1, in_valid = 1 for 8 cycles, in_data = 1..8.
  - out_data = 1..8 on consecutive cycles, 1-cycle latency.
  - in_ready stays 1 and occupancy stays 1.
- Stall absorb: stream 0xA, 0xB, 0xC, drop out_ready after 0xA is presented.
  - 0xB is held in main and 0xC in skid; occupancy = 2 and in_ready = 0 next cycle.
  - On out_ready = 1, the output sequence is 0xB then 0xC, with no loss or duplication.
- Flush while FULL: occupancy = 2, assert flush with in_valid = 1, in_data = 0x55.
  - Next cycle out_valid = 0, occupancy = 0, in_ready = 1.
  - 0x55 never appears on out_data.
- Flush with simultaneous out_fire: main = 0x11, out_ready = 1, flush = 1.
  - 0x11 counts as consumed and the stage is EMPTY afterwards.
  - With PIPE_SKID_ZERO_EN defined, out_data = 0 afterwards.
- Async reset mid-FULL: assert reset between clock edges.
  - Immediately out_valid = 0, occupancy = 0, in_ready = 1, out_data = 0.
  - After deassertion, the first accepted payload emerges 1 cycle later.
- Width sweep: DATA_W = 1 and DATA_W = 130 with random valid/ready traffic.
  - Scoreboard confirms in-order, lossless delivery.
  - A payload never changes while out_valid & !out_ready.
